// File: rtl/spi_flash_arbiter_if.sv
// Bundle of requester-side and SPI-flash-master-side signals for spi_flash_arbiter.
// The arbiter connects through the master modport; a requester/flash model uses slave.
interface spi_flash_arbiter_if #(
  parameter int LEN_W = 15
);
  logic             r0_req;
  logic             r0_rd;
  logic [23:0]      r0_addr;
  logic [LEN_W-1:0] r0_len;
  logic [7:0]       r0_wdata;
  logic             r0_gnt;
  logic             r0_rvalid;
  logic [7:0]       r0_rdata;
  logic             r0_done;
  logic             r0_err;

  logic             r1_req;
  logic             r1_rd;
  logic [23:0]      r1_addr;
  logic [LEN_W-1:0] r1_len;
  logic [7:0]       r1_wdata;
  logic             r1_gnt;
  logic             r1_rvalid;
  logic [7:0]       r1_rdata;
  logic             r1_done;
  logic             r1_err;

  logic             m_en;
  logic [23:0]      m_addr;
  logic             m_read_req;
  logic [LEN_W+2:0] m_words_to_read;
  logic [7:0]       m_wr_data;
  logic             m_valid;
  logic [7:0]       m_rd_data;
  logic             m_end_transaction;
  logic             m_rd_ack;

  modport master (
    input  r0_req, r0_rd, r0_addr, r0_len, r0_wdata,
    output r0_gnt, r0_rvalid, r0_rdata, r0_done, r0_err,
    input  r1_req, r1_rd, r1_addr, r1_len, r1_wdata,
    output r1_gnt, r1_rvalid, r1_rdata, r1_done, r1_err,
    output m_en, m_addr, m_read_req, m_words_to_read, m_wr_data, m_rd_ack,
    input  m_valid, m_rd_data, m_end_transaction
  );

  modport slave (
    output r0_req, r0_rd, r0_addr, r0_len, r0_wdata,
    input  r0_gnt, r0_rvalid, r0_rdata, r0_done, r0_err,
    output r1_req, r1_rd, r1_addr, r1_len, r1_wdata,
    input  r1_gnt, r1_rvalid, r1_rdata, r1_done, r1_err,
    input  m_en, m_addr, m_read_req, m_words_to_read, m_wr_data, m_rd_ack,
    output m_valid, m_rd_data, m_end_transaction
  );
endinterface

// File: rtl/spi_flash_arbiter.sv
// Round-robin arbiter sharing one N25Q032A SPI flash master between the boot
// loader (requester 0) and the CPU data port (requester 1). One transaction at
// a time; byte lengths are converted to the master's bit count.
// Optional macro SPI_ARB_BYTECOUNT_EN: counts forwarded read bytes and flags
// rN_err at completion when the count differs from the requested length.
module spi_flash_arbiter #(
  parameter int LEN_W    = 15,
  parameter int WR_GUARD = 128
) (
  input logic clk,
  input logic reset,
  spi_flash_arbiter_if.master bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] RD_STREAM = 3'd2;
  localparam logic [2:0] ACK       = 3'd3;
  localparam logic [2:0] WR_WAIT   = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  localparam int GW = $clog2(WR_GUARD + 1);

  logic [2:0]       state;
  logic             last;
  logic             owner;
  logic             rd_q;
  logic [23:0]      addr_q;
  logic [LEN_W-1:0] len_q;
  logic [7:0]       wdata_q;
  logic [GW-1:0]    guard;
  logic             en_q;
  logic             ack_q;
  logic [1:0]       rvalid_q;
  logic [7:0]       rdata_q;
  logic [1:0]       done_q;
  logic [1:0]       err_q;
  logic             err_now;
`ifdef SPI_ARB_BYTECOUNT_EN
  logic [LEN_W-1:0] cnt;
`endif

  logic [1:0]       gnt;
  logic             pick;
  logic             sel_rd;
  logic [23:0]      sel_addr;
  logic [LEN_W-1:0] sel_len;
  logic [7:0]       sel_wdata;

  // Grant decision: only in IDLE; on a tie the requester not granted last wins.
  always_comb begin
    gnt  = 2'b00;
    pick = 1'b0;
    if (!reset && state == IDLE) begin
      if (bus.r0_req && bus.r1_req) pick = ~last;
      else                          pick = bus.r1_req;
      if (bus.r0_req || bus.r1_req) gnt = pick ? 2'b10 : 2'b01;
    end
  end

  assign sel_rd    = pick ? bus.r1_rd    : bus.r0_rd;
  assign sel_addr  = pick ? bus.r1_addr  : bus.r0_addr;
  assign sel_len   = pick ? bus.r1_len   : bus.r0_len;
  assign sel_wdata = pick ? bus.r1_wdata : bus.r0_wdata;

`ifdef SPI_ARB_BYTECOUNT_EN
  assign err_now = rd_q && (cnt != len_q);
`else
  assign err_now = 1'b0;
`endif

  // Transaction sequencer: latches the granted request and drives the master.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      owner    <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      wdata_q  <= '0;
      guard    <= '0;
      en_q     <= 1'b0;
      ack_q    <= 1'b0;
      rvalid_q <= 2'b00;
      rdata_q  <= '0;
      done_q   <= 2'b00;
      err_q    <= 2'b00;
`ifdef SPI_ARB_BYTECOUNT_EN
      cnt      <= '0;
`endif
    end else begin
      en_q     <= 1'b0;
      ack_q    <= 1'b0;
      rvalid_q <= 2'b00;
      done_q   <= 2'b00;
      err_q    <= 2'b00;
      case (state)
        IDLE: begin
          if (gnt != 2'b00) begin
            owner   <= pick;
            last    <= pick;
            rd_q    <= sel_rd;
            addr_q  <= sel_addr;
            len_q   <= sel_len;
            wdata_q <= sel_wdata;
`ifdef SPI_ARB_BYTECOUNT_EN
            cnt     <= '0;
`endif
            // A zero-length read never touches the master.
            state   <= (sel_rd && sel_len == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          en_q <= 1'b1;
          if (rd_q) begin
            state <= RD_STREAM;
          end else begin
            guard <= GW'(WR_GUARD - 1);
            state <= WR_WAIT;
          end
        end
        RD_STREAM: begin
          if (bus.m_valid) begin
            rvalid_q[owner] <= 1'b1;
            rdata_q         <= bus.m_rd_data;
`ifdef SPI_ARB_BYTECOUNT_EN
            if (cnt != '1) cnt <= cnt + 1'b1;
`endif
          end
          if (bus.m_end_transaction) state <= ACK;
        end
        ACK: begin
          ack_q <= 1'b1;
          state <= DONE;
        end
        WR_WAIT: begin
          // No completion comes back for writes; wait out a fixed guard time.
          if (guard == '0) state <= DONE;
          else             guard <= guard - 1'b1;
        end
        DONE: begin
          done_q[owner] <= 1'b1;
          err_q[owner]  <= err_now;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.r0_gnt    = gnt[0];
  assign bus.r1_gnt    = gnt[1];
  assign bus.r0_rvalid = rvalid_q[0];
  assign bus.r1_rvalid = rvalid_q[1];
  assign bus.r0_rdata  = rvalid_q[0] ? rdata_q : 8'h00;
  assign bus.r1_rdata  = rvalid_q[1] ? rdata_q : 8'h00;
  assign bus.r0_done   = done_q[0];
  assign bus.r1_done   = done_q[1];
  assign bus.r0_err    = err_q[0];
  assign bus.r1_err    = err_q[1];

  assign bus.m_en            = en_q;
  assign bus.m_addr          = addr_q;
  assign bus.m_read_req      = rd_q;
  assign bus.m_words_to_read = {len_q, 3'b000};
  assign bus.m_wr_data       = wdata_q;
  assign bus.m_rd_ack        = ack_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Self-checking bench for spi_flash_arbiter: directed scenarios followed by
// randomized single and simultaneous requests, checked against a transaction-
// level reference (round-robin pointer, expected bytes, completion timing).
module tb_spi_flash_arbiter;
  localparam int LEN_W    = 15;
  localparam int WR_GUARD = 128;

  typedef struct {
    int               id;
    logic             rd;
    logic [23:0]      addr;
    logic [LEN_W-1:0] len;
    logic [7:0]       wd;
    int               nflash;
  } txn_t;

  typedef struct {
    int              cyc;
    int              id;
    logic            rd;
    logic [23:0]     a;
    logic [LEN_W+2:0] w;
    logic [7:0]      d;
    logic            e;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   last_m = 1;
  int   last_ack = -100;

  ev_t  gnt_log[$];
  ev_t  en_log[$];
  ev_t  ack_log[$];
  ev_t  rx_log[$];
  ev_t  done_log[$];
  logic [7:0] fq[$];
  int         fcount[$];
  logic [7:0] preset[$];
  logic [7:0] expb[2][$];

  spi_flash_arbiter_if #(.LEN_W(LEN_W)) bus();

  spi_flash_arbiter #(.LEN_W(LEN_W), .WR_GUARD(WR_GUARD)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    logic [127:0] v;
    v = 128'({bus.r0_gnt, bus.r0_rvalid, bus.r0_rdata, bus.r0_done, bus.r0_err,
              bus.r1_gnt, bus.r1_rvalid, bus.r1_rdata, bus.r1_done, bus.r1_err,
              bus.m_en, bus.m_addr, bus.m_read_req, bus.m_words_to_read,
              bus.m_wr_data, bus.m_rd_ack});
    return v;
  endfunction

  function automatic txn_t mk(int id, logic rd, logic [23:0] a, int len, logic [7:0] wd, int nf);
    txn_t t;
    t.id = id; t.rd = rd; t.addr = a; t.len = LEN_W'(len); t.wd = wd; t.nflash = nf;
    return t;
  endfunction

  function automatic logic exp_err(txn_t t);
`ifdef SPI_ARB_BYTECOUNT_EN
    return t.rd && (t.nflash != int'(t.len));
`else
    return 1'b0 & t.rd;
`endif
  endfunction

  // Event recorder: everything the DUT emits, stamped with the cycle number.
  always @(negedge clk) begin
    ev_t ev;
    ev = '{cyc: cyc, id: 0, rd: bus.m_read_req, a: bus.m_addr,
           w: bus.m_words_to_read, d: bus.m_wr_data, e: 1'b0};
    if (bus.r0_gnt) begin ev.id = 0; gnt_log.push_back(ev); end
    if (bus.r1_gnt) begin ev.id = 1; gnt_log.push_back(ev); end
    if (bus.m_en) begin
      check("en_gap_after_ack", (cyc - last_ack) >= 3, 1'b1);
      en_log.push_back(ev);
    end
    if (bus.m_rd_ack) begin ack_log.push_back(ev); last_ack = cyc; end
    if (bus.r0_rvalid) begin ev.id = 0; ev.d = bus.r0_rdata; rx_log.push_back(ev); end
    if (bus.r1_rvalid) begin ev.id = 1; ev.d = bus.r1_rdata; rx_log.push_back(ev); end
    if (bus.r0_done) begin ev.id = 0; ev.e = bus.r0_err; done_log.push_back(ev); end
    if (bus.r1_done) begin ev.id = 1; ev.e = bus.r1_err; done_log.push_back(ev); end
  end

  // Flash master model: on a read en, streams the queued bytes, holds
  // end_transaction until rd_ack, and abandons everything on reset.
  initial begin : flash
    int n;
    logic [7:0] bl[$];
    logic ab;
    bus.m_valid = 1'b0;
    bus.m_rd_data = 8'h00;
    bus.m_end_transaction = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && bus.m_en && bus.m_read_req) begin
        n = (fcount.size() > 0) ? fcount.pop_front() : 0;
        bl.delete();
        for (int i = 0; i < n; i++) bl.push_back((fq.size() > 0) ? fq.pop_front() : 8'h00);
        @(negedge clk);
        ab = reset;
        for (int i = 0; i < n && !ab; i++) begin
          bus.m_valid = 1'b1;
          bus.m_rd_data = bl[i];
          bus.m_end_transaction = (i == n - 1);
          @(negedge clk);
          if (reset) ab = 1'b1;
          bus.m_valid = 1'b0;
          if (!ab && i < n - 1 && $urandom_range(0, 1) == 1) begin
            @(negedge clk);
            if (reset) ab = 1'b1;
          end
        end
        if (!ab) begin
          bus.m_end_transaction = 1'b1;
          for (int k = 0; k < 40 && !ab && !bus.m_rd_ack; k++) begin
            @(negedge clk);
            if (reset) ab = 1'b1;
          end
        end
        bus.m_valid = 1'b0;
        bus.m_end_transaction = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic load_flash(input txn_t t);
    logic [7:0] b;
    expb[t.id].delete();
    if (t.rd && t.len != '0) begin
      fcount.push_back(t.nflash);
      for (int i = 0; i < t.nflash; i++) begin
        b = (preset.size() > 0) ? preset.pop_front() : 8'($urandom);
        fq.push_back(b);
        expb[t.id].push_back(b);
      end
    end
  endtask

  task automatic drive(input txn_t t);
    if (t.id == 0) begin
      bus.r0_req = 1'b1; bus.r0_rd = t.rd; bus.r0_addr = t.addr;
      bus.r0_len = t.len; bus.r0_wdata = t.wd;
    end else begin
      bus.r1_req = 1'b1; bus.r1_rd = t.rd; bus.r1_addr = t.addr;
      bus.r1_len = t.len; bus.r1_wdata = t.wd;
    end
  endtask

  // Drop the request after its grant and scramble the fields.
  task automatic release_req(input int id);
    @(posedge clk); #1;
    if (id == 0) begin
      bus.r0_req = 1'b0; bus.r0_rd = 1'($urandom_range(0, 1)); bus.r0_addr = 24'($urandom);
      bus.r0_len = LEN_W'($urandom); bus.r0_wdata = 8'($urandom);
    end else begin
      bus.r1_req = 1'b0; bus.r1_rd = 1'($urandom_range(0, 1)); bus.r1_addr = 24'($urandom);
      bus.r1_len = LEN_W'($urandom); bus.r1_wdata = 8'($urandom);
    end
  endtask

  task automatic wait_gnt(input int after, output int who, output int g);
    bit found;
    found = 1'b0; who = -1; g = cyc;
    for (int k = 0; k < 400 && !found; k++) begin
      foreach (gnt_log[i])
        if (!found && gnt_log[i].cyc > after) begin
          found = 1'b1; who = gnt_log[i].id; g = gnt_log[i].cyc;
        end
      if (!found) begin @(negedge clk); #1; end
    end
  endtask

  task automatic finish_txn(input string tag, input txn_t t, input int g);
    bit   found;
    ev_t  de, ee;
    int   ne, na, ac, nother;
    logic zero;
    logic [7:0] got[$];
    found = 1'b0;
    de = '{cyc: cyc, id: -1, rd: 1'b0, a: '0, w: '0, d: '0, e: 1'bx};
    ee = de;
    for (int k = 0; k < 400 && !found; k++) begin
      foreach (done_log[i])
        if (!found && done_log[i].cyc > g) begin found = 1'b1; de = done_log[i]; end
      if (!found) begin @(negedge clk); #1; end
    end
    check({tag, "_done_seen"}, found, 1'b1);
    check({tag, "_done_id"}, de.id, t.id);
    check({tag, "_err"}, de.e, exp_err(t));
    zero = t.rd && (t.len == '0);
    ne = 0; na = 0; ac = -1000;
    foreach (en_log[i])
      if (en_log[i].cyc > g && en_log[i].cyc < de.cyc) begin
        if (ne == 0) ee = en_log[i];
        ne++;
      end
    foreach (ack_log[i])
      if (ack_log[i].cyc > g && ack_log[i].cyc < de.cyc) begin na++; ac = ack_log[i].cyc; end
    check({tag, "_en_count"}, ne, zero ? 0 : 1);
    if (!zero) begin
      check({tag, "_m_read_req"}, ee.rd, t.rd);
      check({tag, "_m_addr"}, ee.a, t.addr);
      if (t.rd) check({tag, "_m_words"}, ee.w, t.len * 8);
      else      check({tag, "_m_wr_data"}, ee.d, t.wd);
    end
    if (zero) begin
      check({tag, "_ack_count"}, na, 0);
      check({tag, "_done_after_gnt"}, de.cyc - g, 2);
    end else if (t.rd) begin
      check({tag, "_ack_count"}, na, 1);
      check({tag, "_done_after_ack"}, de.cyc - ac, 1);
    end else begin
      check({tag, "_ack_count"}, na, 0);
      check({tag, "_done_after_en"}, de.cyc - ee.cyc, WR_GUARD + 1);
    end
    nother = 0;
    foreach (rx_log[i])
      if (rx_log[i].cyc > g && rx_log[i].cyc <= de.cyc) begin
        if (rx_log[i].id == t.id) got.push_back(rx_log[i].d);
        else nother++;
      end
    check({tag, "_other_rx"}, nother, 0);
    check({tag, "_nbytes"}, got.size(), expb[t.id].size());
    for (int i = 0; i < got.size() && i < expb[t.id].size(); i++)
      check({tag, "_byte"}, got[i], expb[t.id][i]);
  endtask

  task automatic single(input string tag, input txn_t t);
    int who, g, after;
    fq.delete(); fcount.delete();
    load_flash(t);
    @(posedge clk); #1;
    drive(t);
    after = cyc - 1;
    wait_gnt(after, who, g);
    check({tag, "_gnt_id"}, who, t.id);
    last_m = t.id;
    release_req(t.id);
    finish_txn(tag, t, g);
  endtask

  // Both requesters raise req in the same cycle; the model predicts the order.
  task automatic pair(input string tag, input txn_t a, input txn_t b);
    txn_t t[2];
    int   first, exp_id, who, g, after;
    t[0] = a; t[1] = b;
    first = (last_m == 1) ? 0 : 1;
    fq.delete(); fcount.delete();
    load_flash(t[first]);
    load_flash(t[1 - first]);
    @(posedge clk); #1;
    drive(t[0]);
    drive(t[1]);
    after = cyc - 1;
    for (int k = 0; k < 2; k++) begin
      exp_id = (k == 0) ? first : 1 - first;
      wait_gnt(after, who, g);
      check({tag, "_gnt_order"}, who, exp_id);
      last_m = exp_id;
      release_req((who < 0) ? exp_id : who);
      finish_txn(tag, t[exp_id], g);
      after = g;
    end
  endtask

  initial begin : main
    int g, who, nrx;
    txn_t ta, tb;
    bus.r0_req = 1'b0; bus.r0_rd = 1'b0; bus.r0_addr = '0; bus.r0_len = '0; bus.r0_wdata = '0;
    bus.r1_req = 1'b0; bus.r1_rd = 1'b0; bus.r1_addr = '0; bus.r1_len = '0; bus.r1_wdata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs(), '0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_m = 1;

    pair("pair_a", mk(0, 1, 24'h000010, 1, 8'h00, 1), mk(1, 1, 24'h000020, 1, 8'h00, 1));
    pair("pair_b", mk(0, 1, 24'h000030, 1, 8'h00, 1), mk(1, 1, 24'h000040, 1, 8'h00, 1));

    preset.delete();
    preset.push_back(8'hA1); preset.push_back(8'hB2);
    preset.push_back(8'hC3); preset.push_back(8'hD4);
    single("read4", mk(0, 1, 24'h001000, 4, 8'h00, 4));
    single("write", mk(1, 0, 24'h000100, 0, 8'h5A, 0));
    single("zero_len", mk(0, 1, 24'h000200, 0, 8'h00, 0));
    single("short_end", mk(0, 1, 24'h000300, 3, 8'h00, 2));
    single("full_three", mk(0, 1, 24'h000300, 3, 8'h00, 3));

    // Reset in the middle of a 16-byte read.
    ta = mk(0, 1, 24'h004000, 16, 8'h00, 16);
    fq.delete(); fcount.delete();
    load_flash(ta);
    @(posedge clk); #1;
    drive(ta);
    wait_gnt(cyc - 1, who, g);
    check("midreset_gnt_id", who, 0);
    release_req(0);
    nrx = 0;
    for (int k = 0; k < 200 && nrx < 5; k++) begin
      @(negedge clk); #1;
      nrx = 0;
      foreach (rx_log[i]) if (rx_log[i].cyc > g && rx_log[i].id == 0) nrx++;
    end
    check("midreset_bytes_before", nrx >= 5, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_outputs", outs(), '0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_m = 1;
    repeat (12) @(negedge clk);
    #1;
    nrx = 0;
    foreach (done_log[i]) if (done_log[i].cyc > g) nrx++;
    check("midreset_no_done", nrx, 0);
    single("after_reset", mk(0, 1, 24'h004100, 2, 8'h00, 2));

    // Randomized traffic.
    for (int it = 0; it < 12; it++) begin
      int mode, l0, l1;
      mode = $urandom_range(0, 2);
      l0 = $urandom_range(0, 5);
      l1 = $urandom_range(0, 5);
      ta = mk(0, ($urandom_range(0, 3) != 0), 24'($urandom), l0, 8'($urandom),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, l0) : l0);
      tb = mk(1, ($urandom_range(0, 3) != 0), 24'($urandom), l1, 8'($urandom),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, l1) : l1);
      if (!ta.rd) ta.nflash = 0;
      if (!tb.rd) tb.nflash = 0;
      if (mode == 0)      single("rand_r0", ta);
      else if (mode == 1) single("rand_r1", tb);
      else                pair("rand_pair", ta, tb);
    end

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
